// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network sequencer blocks:
// instruction word, END_OF_PROGRAM marker and fetch FSM state encoding.
package nn_pkg;

  localparam int unsigned INSTR_WIDTH = 8;
  localparam int unsigned COUNT_WIDTH = 8;

  localparam logic [INSTR_WIDTH-1:0] END_OF_PROGRAM = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } fetch_state_t;

  // Saturating increment for the issue counter
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == {COUNT_WIDTH{1'b1}}) ? v : v + COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Walks the instruction RAM from address 0 and issues one word per valid/ready
// handshake until END_OF_PROGRAM, or flags an error at the last address.
module instruction_fetch_unit
  import nn_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = INSTR_WIDTH,
  parameter int unsigned LAST_ADDR  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [ADDR_WIDTH-1:0]  instr_ram_address,
  output logic                   instr_ram_enable,
  input  logic [DATA_WIDTH-1:0]  instr_ram_data,
  output logic [DATA_WIDTH-1:0]  instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  fetch_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]  addr_nxt;
  logic [DATA_WIDTH-1:0]  instr_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic                   valid_nxt;
  logic                   enable_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;
  logic                   error_nxt;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      instr_ram_address <= '0;
      instr_ram_enable  <= 1'b0;
      instr             <= '0;
      instr_valid       <= 1'b0;
      instr_count       <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
    end else begin
      state             <= state_nxt;
      instr_ram_address <= addr_nxt;
      instr_ram_enable  <= enable_nxt;
      instr             <= instr_nxt;
      instr_valid       <= valid_nxt;
      instr_count       <= count_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      error             <= error_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    addr_nxt  = instr_ram_address;
    instr_nxt = instr;
    valid_nxt = instr_valid;
    count_nxt = instr_count;
    done_nxt  = done;
    error_nxt = error;

    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt  = '0;
          count_nxt = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (instr_ram_data == DATA_WIDTH'(END_OF_PROGRAM)) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          instr_nxt = instr_ram_data;
          valid_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          valid_nxt = 1'b0;
          count_nxt = sat_inc(instr_count);
          // The address never moves past the last slot; running out is an error
          if (instr_ram_address == ADDR_WIDTH'(LAST_ADDR)) begin
            error_nxt = 1'b1;
            state_nxt = ERROR;
          end else begin
            addr_nxt  = instr_ram_address + ADDR_WIDTH'(1);
            state_nxt = FETCH;
          end
        end
      end
      DONE, ERROR: begin
        if (start) begin
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
          addr_nxt  = '0;
          count_nxt = '0;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Decoded from the next state so these stay registered yet track the FSM
    enable_nxt = (state_nxt == FETCH);
    busy_nxt   = (state_nxt == FETCH) || (state_nxt == ISSUE);
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational RAM model;
// expected values are hand-derived cycle by cycle.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] instr_ram_address;
  logic       instr_ram_enable;
  logic [7:0] instr_ram_data;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_count;
  logic       busy;
  logic       done;
  logic       error;

  logic [7:0] ram [8];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .LAST_ADDR (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .instr_ram_address(instr_ram_address),
    .instr_ram_enable (instr_ram_enable),
    .instr_ram_data   (instr_ram_data),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_count      (instr_count),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  // Combinational RAM; unused slots above the program read as the marker
  always_comb begin
    if (!instr_ram_enable)
      instr_ram_data = 8'h00;
    else if (instr_ram_address > 8'd7)
      instr_ram_data = 8'hFF;
    else
      instr_ram_data = ram[instr_ram_address[2:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic [7:0] e);
    ram[0] = a; ram[1] = b; ram[2] = c; ram[3] = d; ram[4] = e;
    ram[5] = 8'hFF; ram[6] = 8'hFF; ram[7] = 8'hFF;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [3];
    prog[0] = 8'd8; prog[1] = 8'd5; prog[2] = 8'd3;

    reset = 1'b1; start = 1'b0; instr_ready = 1'b1;
    load(8'd8, 8'd5, 8'd3, 8'hFF, 8'hFF);
    step(); step();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr",  32'(instr_ram_address), 32'd0);
    check("rst_en",    32'(instr_ram_enable), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_flags", {30'd0, done, error}, 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    reset = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Normal program 8,5,3 then marker
    pulse_start();
    check("n_fetch_en", 32'(instr_ram_enable), 32'd1);
    check("n_fetch_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("n_fetch_addr", 32'(instr_ram_address), 32'(i));
      step();
      check("n_valid", 32'(instr_valid), 32'd1);
      check("n_instr", 32'(instr), 32'(prog[i]));
      check("n_issue_addr", 32'(instr_ram_address), 32'(i));
      check("n_issue_en", 32'(instr_ram_enable), 32'd0);
      step();
      check("n_count", 32'(instr_count), 32'(i + 1));
      check("n_valid_lo", 32'(instr_valid), 32'd0);
    end
    check("n_marker_addr", 32'(instr_ram_address), 32'd3);
    check("n_pre_done", 32'(done), 32'd0);
    step();
    check("n_done", 32'(done), 32'd1);
    check("n_error", 32'(error), 32'd0);
    check("n_count_final", 32'(instr_count), 32'd3);
    check("n_busy_end", 32'(busy), 32'd0);

    // Restart from DONE with backpressure, plus a start pulse while in ISSUE
    instr_ready = 1'b0;
    pulse_start();
    check("bp_done_clr", 32'(done), 32'd0);
    check("bp_count_clr", 32'(instr_count), 32'd0);
    check("bp_addr0", 32'(instr_ram_address), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", 32'(instr), 32'd8);
      check("bp_addr", 32'(instr_ram_address), 32'd0);
      step();
      start = 1'b0;
    end
    instr_ready = 1'b1;
    step();
    check("bp_resume_addr", 32'(instr_ram_address), 32'd1);
    check("bp_resume_cnt", 32'(instr_count), 32'd1);
    instr_ready = 1'b0;
    step();
    check("bp_instr5", 32'(instr), 32'd5);
    check("bp_valid5", 32'(instr_valid), 32'd1);

    // Reset while holding instruction 5 in ISSUE
    reset = 1'b1;
    step();
    reset = 1'b0;
    instr_ready = 1'b1;
    check("mr_valid", 32'(instr_valid), 32'd0);
    check("mr_addr", 32'(instr_ram_address), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_count", 32'(instr_count), 32'd0);
    step();
    check("mr_idle_en", 32'(instr_ram_enable), 32'd0);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_instr", 32'(instr), 32'(prog[i]));
      step();
    end
    step();
    check("mr_done", 32'(done), 32'd1);
    check("mr_count_final", 32'(instr_count), 32'd3);

    // Empty program
    load(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pulse_start();
    check("e_valid0", 32'(instr_valid), 32'd0);
    check("e_done0", 32'(done), 32'd0);
    step();
    check("e_done", 32'(done), 32'd1);
    check("e_valid1", 32'(instr_valid), 32'd0);
    check("e_count", 32'(instr_count), 32'd0);

    // Missing marker: all five slots hold instructions
    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check("mm_addr", 32'(instr_ram_address), 32'(i));
      step();
      check("mm_instr", 32'(instr), 32'(i + 1));
      step();
    end
    check("mm_error", 32'(error), 32'd1);
    check("mm_done", 32'(done), 32'd0);
    check("mm_addr_last", 32'(instr_ram_address), 32'd4);
    check("mm_count", 32'(instr_count), 32'd5);
    check("mm_busy", 32'(busy), 32'd0);
    step(); step();
    check("mm_error_held", 32'(error), 32'd1);
    check("mm_addr_held", 32'(instr_ram_address), 32'd4);
    check("mm_en_off", 32'(instr_ram_enable), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
